dcache_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 22 ++
 rtl/dcache_array.sv | 50 +++++
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and geometry constants for the direct-mapped data cache.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } dcache_state_t;

    localparam int DC_TAG_W   = 3;
    localparam int DC_IDX_W   = 3;
    localparam int DC_OFF_W   = 2;
    localparam int DC_LINES   = 8;
    localparam int DC_BLOCK_W = 32;

    function automatic logic [7:0] dc_byte_sel(input logic [DC_BLOCK_W-1:0] blk,
                                               input logic [DC_OFF_W-1:0]   off);
        return blk[8*off +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage (valid, dirty, tag, data) for the data cache; one indexed line is
// visible combinationally, and a fill has priority over a byte store.
module dcache_array
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DC_IDX_W-1:0]   index,
    output logic                  line_valid,
    output logic                  line_dirty,
    output logic [DC_TAG_W-1:0]   line_tag,
    output logic [DC_BLOCK_W-1:0] line_data,
    input  logic                  fill_en,
    input  logic [DC_TAG_W-1:0]   fill_tag,
    input  logic [DC_BLOCK_W-1:0] fill_data,
    input  logic                  wr_en,
    input  logic [DC_OFF_W-1:0]   wr_offset,
    input  logic [7:0]            wr_byte
);

    logic [DC_LINES-1:0]   valid;
    logic [DC_LINES-1:0]   dirty;
    logic [DC_TAG_W-1:0]   tags [DC_LINES];
    logic [DC_BLOCK_W-1:0] data [DC_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < DC_LINES; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else if (fill_en) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
            tags[index]  <= fill_tag;
            data[index]  <= fill_data;
        end else if (wr_en) begin
            dirty[index]                  <= 1'b1;
            data[index][8*wr_offset +: 8] <= wr_byte;
        end
    end

    assign line_valid = valid[index];
    assign line_dirty = dirty[index];
    assign line_tag   = tags[index];
    assign line_data  = data[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with busy-wait memory port.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | serve hits; a miss starts a writeback or fetch
// WRITEBACK | dirty victim block sent to memory
// FETCH     | requested block read from memory
// FILL      | fetched block written into the line
module dcache_ctrl
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_WRITEBACK = WRITEBACK;
    localparam logic [1:0] ST_FETCH     = FETCH;
    localparam logic [1:0] ST_FILL      = FILL;

    logic [1:0]            state;
    logic [DC_BLOCK_W-1:0] fill_buf;

    logic [DC_TAG_W-1:0]   addr_tag;
    logic [DC_IDX_W-1:0]   addr_idx;
    logic [DC_OFF_W-1:0]   addr_off;
    logic                  line_valid;
    logic                  line_dirty;
    logic [DC_TAG_W-1:0]   line_tag;
    logic [DC_BLOCK_W-1:0] line_data;
    logic                  req;
    logic                  hit;
    logic                  idle;
    logic                  fill_en;
    logic                  wr_en;

    assign addr_tag = ADDRESS[7:5];
    assign addr_idx = ADDRESS[4:2];
    assign addr_off = ADDRESS[1:0];

    assign req     = READ | WRITE;
    assign hit     = line_valid && (line_tag == addr_tag);
    assign idle    = (state == ST_IDLE);
    assign fill_en = (state == ST_FILL);
    assign wr_en   = idle && WRITE && hit;

    assign BUSYWAIT = (req && !hit && idle) || !idle;
    assign READDATA = hit ? dc_byte_sel(line_data, addr_off) : 8'h00;

    dcache_array u_array (
        .clk        (CLK),
        .rst_n      (RESET),
        .index      (addr_idx),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .fill_en    (fill_en),
        .fill_tag   (addr_tag),
        .fill_data  (fill_buf),
        .wr_en      (wr_en),
        .wr_offset  (addr_off),
        .wr_byte    (WRITEDATA)
    );

    // Memory-side outputs are set on entry to each transfer state so they stay flat for its duration.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= ST_IDLE;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            fill_buf      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && !hit) begin
                        if (line_dirty) begin
                            state         <= ST_WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {line_tag, addr_idx};
                            MEM_WRITEDATA <= line_data;
                        end else begin
                            state       <= ST_FETCH;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= ADDRESS[7:2];
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state         <= ST_FETCH;
                        MEM_WRITE     <= 1'b0;
                        MEM_WRITEDATA <= '0;
                        MEM_READ      <= 1'b1;
                        MEM_ADDRESS   <= ADDRESS[7:2];
                    end
                end
                ST_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state       <= ST_FILL;
                        MEM_READ    <= 1'b0;
                        MEM_ADDRESS <= '0;
                        fill_buf    <= MEM_READDATA;
                    end
                end
                ST_FILL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [1:0] prev_state;

    // The completion that follows a fill is the tail of a miss, not a new hit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prev_state <= ST_IDLE;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            prev_state <= state;
            if (idle && req) begin
                if (hit) begin
                    if (prev_state != ST_FILL && HIT_COUNT != 16'hFFFF)
                        HIT_COUNT <= HIT_COUNT + 16'd1;
                end else if (MISS_COUNT != 16'hFFFF) begin
                    MISS_COUNT <= MISS_COUNT + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected loads and memory transfers,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dcache_ctrl;

    localparam int MEM_LAT = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    mem_exp_t   mem_q[$];
    logic [7:0] rd_q[$];

    logic [31:0] mem [64];
    logic        mem_loaded = 1'b0;
    int          mcnt = 0;

    always #5 CLK = ~CLK;

    dcache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    // Memory: busy for MEM_LAT-1 edges of a held request, done on the next.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < MEM_LAT - 1);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h5500_0000 | i;
            mem[6'h00] <= 32'h0302_0100;
            mem[6'h09] <= 32'hDDCC_BBAA;
            mem[6'h11] <= 32'h4433_2211;
            mem[6'h20] <= 32'h0F0E_0D0C;
            mem_loaded <= 1'b1;
        end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
        if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    always @(negedge CLK) begin
        mem_exp_t   me;
        logic [7:0] re;
        if (RESET) begin
            if (MEM_READ && MEM_WRITE) begin
                total++;
                bad++;
                $display("FAIL mem_exclusive: MEM_READ and MEM_WRITE both high at %0t", $time);
            end
            if (READ && !WRITE && !BUSYWAIT) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL load_unexpected: addr=%0h data=%0h", ADDRESS, READDATA);
                end else begin
                    re = rd_q.pop_front();
                    if (READDATA !== re) begin
                        bad++;
                        $display("FAIL load_data: addr=%0h got=%0h want=%0h", ADDRESS, READDATA, re);
                    end
                end
            end
            if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_unexpected: wr=%0b addr=%0h", MEM_WRITE, MEM_ADDRESS);
                end else begin
                    me = mem_q.pop_front();
                    if (MEM_WRITE !== me.wr || MEM_ADDRESS !== me.addr ||
                        (me.wr && MEM_WRITEDATA !== me.data)) begin
                        bad++;
                        $display("FAIL mem_xfer: got wr=%0b addr=%0h data=%0h want wr=%0b addr=%0h data=%0h",
                                 MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, me.wr, me.addr, me.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input int h, input int m);
`ifdef DCACHE_STATS_EN
        chk("hit_count", 32'(HIT_COUNT), h);
        chk("miss_count", 32'(MISS_COUNT), m);
`endif
    endtask

    task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
        mem_exp_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        mem_q.push_back(e);
    endtask

    // Called #1 after a posedge; returns the number of cycles BUSYWAIT was high.
    task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, output int stall);
        int n = 0;
        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        @(negedge CLK);
        while (BUSYWAIT && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL cpu_timeout: addr=%0h still stalled after %0d cycles", a, n);
        end
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
        stall = n;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busywait"}, 32'(BUSYWAIT), 0);
        chk({tag, "_mem_rw"}, {30'd0, MEM_READ, MEM_WRITE}, 0);
        chk({tag, "_mem_addr"}, 32'(MEM_ADDRESS), 0);
        chk({tag, "_mem_wdata"}, MEM_WRITEDATA, 0);
        chk({tag, "_readdata"}, 32'(READDATA), 0);
    endtask

    initial begin
        int n;
        RESET = 1'b0;
        READ = 1'b0;
        WRITE = 1'b0;
        ADDRESS = 8'h00;
        WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk_quiet("reset");
        chk_stats(0, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // cold read miss
        push_mem(1'b0, 6'h09, 32'h0);
        rd_q.push_back(8'hBB);
        cpu_op(1'b1, 1'b0, 8'h25, 8'h00, n);
        chk("cold_stall", n, 7);
        chk_stats(0, 1);

        // read hits
        rd_q.push_back(8'hBB);
        cpu_op(1'b1, 1'b0, 8'h25, 8'h00, n);
        chk("hit_stall_25", n, 0);
        rd_q.push_back(8'hDD);
        cpu_op(1'b1, 1'b0, 8'h27, 8'h00, n);
        chk("hit_stall_27", n, 0);
        chk_stats(2, 0 + 1);

        // write hit, then dirty eviction by 0x45
        cpu_op(1'b0, 1'b1, 8'h24, 8'h5A, n);
        chk("wr_hit_stall", n, 0);
        push_mem(1'b1, 6'h09, 32'hDDCC_BB5A);
        push_mem(1'b0, 6'h11, 32'h0);
        rd_q.push_back(8'h22);
        cpu_op(1'b1, 1'b0, 8'h45, 8'h00, n);
        chk("dirty_stall", n, 12);
        chk_stats(3, 2);

        // write miss allocate, then verify byte and dirtiness via eviction
        push_mem(1'b0, 6'h20, 32'h0);
        cpu_op(1'b0, 1'b1, 8'h80, 8'h77, n);
        chk("wr_miss_stall", n, 7);
        rd_q.push_back(8'h77);
        cpu_op(1'b1, 1'b0, 8'h80, 8'h00, n);
        chk("alloc_byte0_stall", n, 0);
        rd_q.push_back(8'h0D);
        cpu_op(1'b1, 1'b0, 8'h81, 8'h00, n);
        chk("alloc_byte1_stall", n, 0);
        push_mem(1'b1, 6'h20, 32'h0F0E_0D77);
        push_mem(1'b0, 6'h00, 32'h0);
        rd_q.push_back(8'h01);
        cpu_op(1'b1, 1'b0, 8'h01, 8'h00, n);
        chk("alloc_evict_stall", n, 12);
        chk_stats(5, 4);

        // reset two cycles into a fetch
        READ = 1'b1;
        ADDRESS = 8'h25;
        repeat (3) @(negedge CLK);
        chk("mid_fetch_mem_read", 32'(MEM_READ), 1);
        RESET = 1'b0;
        READ = 1'b0;
        #1;
        chk_quiet("mid_reset");
        chk_stats(0, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        push_mem(1'b0, 6'h09, 32'h0);
        rd_q.push_back(8'hBB);
        cpu_op(1'b1, 1'b0, 8'h25, 8'h00, n);
        chk("post_reset_stall", n, 7);
        chk_stats(0, 1);

        // READ and WRITE together act as a store
        cpu_op(1'b1, 1'b1, 8'h26, 8'h11, n);
        chk("rw_stall", n, 0);
        rd_q.push_back(8'h11);
        cpu_op(1'b1, 1'b0, 8'h26, 8'h00, n);
        chk("rw_readback_stall", n, 0);
        chk_stats(2, 1);

        repeat (3) @(posedge CLK);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
